// File: rtl/adf4030_trig_scheduler.sv
// rtl/adf4030_trig_scheduler.sv - round-robin trigger scheduler for ADF4030 trigger channels
// Optional watchdog on SYNC/HOLD waits: define ADF4030_TRIG_SCHED_TIMEOUT_EN.
module adf4030_trig_scheduler #(
    parameter int REQ_COUNT      = 4,
    parameter int CHANNEL_COUNT  = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [REQ_COUNT-1:0]          req_valid,
    output logic [REQ_COUNT-1:0]          req_ready,
    input  logic [REQ_COUNT*CHANNEL_COUNT-1:0] req_ch_mask,
    input  logic [REQ_COUNT*16-1:0]       req_phase,
    input  logic [3:0]                    holdoff,
    input  logic                          bsync_ready,
    input  logic                          bsync_event,
    input  logic [15:0]                   bsync_ratio,
    output logic [CHANNEL_COUNT-1:0]      ch_en,
    output logic [CHANNEL_COUNT*16-1:0]   ch_phase,
    output logic                          trig,
    output logic                          busy,
    output logic [2:0]                    grant_id,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    typedef enum logic [2:0] {IDLE, SETUP, SYNC, FIRE, HOLD} state_t;

    state_t                     state_q;
    logic [2:0]                 rr_ptr_q;
    logic [CHANNEL_COUNT-1:0]   ch_en_q;
    logic [15:0]                phase_q;
    logic                       trig_q, busy_q, done_q, err_q;
    logic [2:0]                 grant_id_q;
    logic [1:0]                 err_code_q;
    logic [4:0]                 hold_cnt_q;

    logic                       gnt_vld;
    logic [2:0]                 gnt_idx;
    logic [CHANNEL_COUNT-1:0]   gnt_mask;
    logic [15:0]                gnt_phase;
    logic                       gnt_bad;
    logic                       tmo_hit;

    always_comb begin
        int idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        gnt_idx   = '0;
        gnt_mask  = '0;
        gnt_phase = '0;
        // Scan starting at rr_ptr, wrapping, first valid requester wins.
        for (int i = 0; i < REQ_COUNT; i++) begin
            idx = (int'(rr_ptr_q) + i) % REQ_COUNT;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                gnt_idx   = 3'(idx);
                gnt_mask  = req_ch_mask[idx*CHANNEL_COUNT +: CHANNEL_COUNT];
                gnt_phase = req_phase[idx*16 +: 16];
            end
        end
        gnt_vld = found && (state_q == IDLE) && bsync_ready;
        gnt_bad = (gnt_mask == '0) || (gnt_phase >= bsync_ratio);
        for (int i = 0; i < REQ_COUNT; i++) begin
            req_ready[i] = gnt_vld && (gnt_idx == 3'(i));
        end
    end

`ifdef ADF4030_TRIG_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else if ((state_q == SYNC || state_q == HOLD) && !bsync_event) begin
            tmo_q <= tmo_q + 1'b1;
        end else if (state_q != FIRE) begin
            tmo_q <= '0;
        end
    end

    assign tmo_hit = (state_q == SYNC || state_q == HOLD) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));
`else
    // Watchdog not built; parameter referenced only to keep the interface uniform.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            ch_en_q    <= '0;
            phase_q    <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (gnt_vld) begin
                    grant_id_q <= gnt_idx;
                    rr_ptr_q   <= (gnt_idx == 3'(REQ_COUNT - 1)) ? 3'd0 : gnt_idx + 3'd1;
                    if (gnt_bad) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'd1;
                    end else begin
                        err_code_q <= 2'd0;
                        ch_en_q    <= gnt_mask;
                        phase_q    <= gnt_phase;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
            end else if (!bsync_ready) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                ch_en_q    <= '0;
                err_q      <= 1'b1;
                err_code_q <= 2'd2;
            end else if (tmo_hit) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                ch_en_q    <= '0;
                err_q      <= 1'b1;
                err_code_q <= 2'd3;
            end else begin
                case (state_q)
                    SETUP: state_q <= SYNC;
                    SYNC: begin
                        if (bsync_event) begin
                            trig_q  <= 1'b1;
                            state_q <= FIRE;
                        end
                    end
                    FIRE: begin
                        hold_cnt_q <= '0;
                        state_q    <= HOLD;
                    end
                    HOLD: begin
                        if (bsync_event) begin
                            if (hold_cnt_q == {1'b0, holdoff}) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                ch_en_q <= '0;
                                state_q <= IDLE;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + 5'd1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ch_en    = ch_en_q;
    assign ch_phase = {CHANNEL_COUNT{phase_q}};
    assign trig     = trig_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
